// File: rtl/rsa_arbiter.sv
// -----------------------------------------------------------------------------
// rsa_arbiter
//
// Shares one modular-exponentiation core (result = a^d mod n) between two
// requesters. A job is granted round-robin, its operands are registered onto
// the core operand bus, the core is started, and the job either completes
// (result registered, done pulse to the owner) or is aborted by a watchdog
// after TIMEOUT wait cycles (core abort pulse, error pulse to the owner).
//
// Timing, in cycles after the IDLE cycle in which a request is seen:
//   +1 START : o_ackK and o_core_start pulse, operands valid on o_core_*
//   +2 WAIT  : watchdog counts 0,1,2,... while waiting for i_core_finished
//   DONE     : one cycle after finish, o_doneK pulses with o_result valid
//   ABORT    : one cycle after the last wait cycle, o_core_rst and o_errK pulse
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_req0 / i_req1               level job requests, held until acked
//   i_a0,i_d0,i_n0 / i_a1,..      256-bit ciphertext, private key, modulus
//   o_ack0 / o_ack1               one-cycle pulse: job accepted
//   o_done0 / o_done1             one-cycle pulse: o_result valid for owner
//   o_err0 / o_err1               one-cycle pulse: job aborted by watchdog
//   o_result                      last completed result, held until next one
//   o_busy                        high in every state except IDLE
//   o_core_a, o_core_d, o_core_n  registered operands to the core
//   o_core_start                  one-cycle start pulse to the core
//   o_core_rst                    one-cycle synchronous abort pulse to the core
//   i_core_result                 core result
//   i_core_finished               one-cycle finish pulse from the core
// -----------------------------------------------------------------------------
module rsa_arbiter #(
    parameter int TIMEOUT = 600000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0,
    input  logic         i_req1,
    input  logic [255:0] i_a0,
    input  logic [255:0] i_d0,
    input  logic [255:0] i_n0,
    input  logic [255:0] i_a1,
    input  logic [255:0] i_d1,
    input  logic [255:0] i_n1,
    output logic         o_ack0,
    output logic         o_ack1,
    output logic         o_done0,
    output logic         o_done1,
    output logic         o_err0,
    output logic         o_err1,
    output logic [255:0] o_result,
    output logic         o_busy,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    output logic         o_core_start,
    output logic         o_core_rst,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished
);

    // Counter only ever holds 0..TIMEOUT-1; TIMEOUT+1 keeps the width >= 1.
    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t        state;
    logic          ptr;     // requester favoured on a simultaneous request
    logic          owner;   // requester that owns the current job
    logic [CW-1:0] wd_cnt;  // watchdog: WAIT cycles spent so far

    logic gnt_any;
    logic gnt_id;

    // Grant decision. A lone request wins regardless of the pointer.
    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        gnt_any = i_req0 | i_req1;
        gnt_id  = 1'b0;
        if (i_req0 && i_req1) begin
            gnt_id = ptr;
        end else if (i_req1) begin
            gnt_id = 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            ptr          <= 1'b0;
            owner        <= 1'b0;
            wd_cnt       <= '0;
            o_ack0       <= 1'b0;
            o_ack1       <= 1'b0;
            o_done0      <= 1'b0;
            o_done1      <= 1'b0;
            o_err0       <= 1'b0;
            o_err1       <= 1'b0;
            o_result     <= '0;
            o_busy       <= 1'b0;
            o_core_a     <= '0;
            o_core_d     <= '0;
            o_core_n     <= '0;
            o_core_start <= 1'b0;
            o_core_rst   <= 1'b0;
        end else begin
            // Pulses are high only in the cycle after the edge that sets them.
            o_ack0       <= 1'b0;
            o_ack1       <= 1'b0;
            o_done0      <= 1'b0;
            o_done1      <= 1'b0;
            o_err0       <= 1'b0;
            o_err1       <= 1'b0;
            o_core_start <= 1'b0;
            o_core_rst   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        owner        <= gnt_id;
                        ptr          <= ~gnt_id;
                        o_ack0       <= ~gnt_id;
                        o_ack1       <= gnt_id;
                        o_core_a     <= gnt_id ? i_a1 : i_a0;
                        o_core_d     <= gnt_id ? i_d1 : i_d0;
                        o_core_n     <= gnt_id ? i_n1 : i_n0;
                        // Start pulse coincides with the ack, in START.
                        o_core_start <= 1'b1;
                        o_busy       <= 1'b1;
                        state        <= S_START;
                    end
                end

                S_START: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end

                S_WAIT: begin
                    // A finish in the last watchdog cycle still completes the job.
                    if (i_core_finished) begin
                        o_result <= i_core_result;
                        o_done0  <= ~owner;
                        o_done1  <= owner;
                        state    <= S_DONE;
                    end else if (wd_cnt == TMAX) begin
                        o_core_rst <= 1'b1;
                        o_err0     <= ~owner;
                        o_err1     <= owner;
                        state      <= S_ABORT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                S_DONE, S_ABORT: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rsa_arbiter
//
// Directed bench for rsa_arbiter with TIMEOUT=16. A small behavioural core
// returns a^d mod n from the registered operands and raises its finish pulse
// a programmable number of cycles after o_core_start (0 = never finishes).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_rsa_arbiter;

    localparam int TO = 16;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_req0 = 1'b0, i_req1 = 1'b0;
    logic [255:0] i_a0 = '0, i_d0 = '0, i_n0 = '0;
    logic [255:0] i_a1 = '0, i_d1 = '0, i_n1 = '0;
    logic         o_ack0, o_ack1, o_done0, o_done1, o_err0, o_err1;
    logic [255:0] o_result;
    logic         o_busy;
    logic [255:0] o_core_a, o_core_d, o_core_n;
    logic         o_core_start, o_core_rst;
    logic [255:0] i_core_result;
    logic         i_core_finished;

    rsa_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(i_req0), .i_req1(i_req1),
        .i_a0(i_a0), .i_d0(i_d0), .i_n0(i_n0),
        .i_a1(i_a1), .i_d1(i_d1), .i_n1(i_n1),
        .o_ack0(o_ack0), .o_ack1(o_ack1),
        .o_done0(o_done0), .o_done1(o_done1),
        .o_err0(o_err0), .o_err1(o_err1),
        .o_result(o_result), .o_busy(o_busy),
        .o_core_a(o_core_a), .o_core_d(o_core_d), .o_core_n(o_core_n),
        .o_core_start(o_core_start), .o_core_rst(o_core_rst),
        .i_core_result(i_core_result), .i_core_finished(i_core_finished)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- behavioural core ----------------
    function automatic logic [255:0] modexp(input logic [255:0] a, d, n);
        logic [511:0] r, b, nn;
        if (n == '0) return '0;
        nn = {256'd0, n};
        r  = 512'd1 % nn;
        b  = {256'd0, a} % nn;
        for (int i = 0; i < 256; i++) begin
            if (d[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[255:0];
    endfunction

    int   core_lat = 0;
    int   core_cnt;
    logic spur = 1'b0;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst)             core_cnt <= 0;
        else if (o_core_rst)   core_cnt <= 0;
        else if (o_core_start) core_cnt <= core_lat;
        else if (core_cnt != 0) core_cnt <= core_cnt - 1;
    end

    assign i_core_finished = (core_cnt == 1) | spur;
    assign i_core_result   = modexp(o_core_a, o_core_d, o_core_n);

    // Pulse tallies for "no stale pulse" checks.
    int n_done0 = 0, n_err0 = 0;
    always @(posedge i_clk) begin
        if (o_done0) n_done0 <= n_done0 + 1;
        if (o_err0)  n_err0  <= n_err0 + 1;
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    function automatic logic hit(input int sel);
        case (sel)
            0:       return o_ack0 | o_ack1;
            1:       return o_done0 | o_done1;
            default: return o_done0 | o_done1 | o_err0 | o_err1;
        endcase
    endfunction

    // Step until the selected event is seen or the budget runs out.
    task automatic wait_ev(input string tag, input int sel, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!hit(sel) && n < max);
        chk({tag, "_seen"}, {255'd0, hit(sel)}, 256'd1);
    endtask

    task automatic set_req0(input logic [255:0] a, d, n);
        i_a0 = a; i_d0 = d; i_n0 = n; i_req0 = 1'b1;
    endtask

    task automatic set_req1(input logic [255:0] a, d, n);
        i_a1 = a; i_d1 = d; i_n1 = n; i_req1 = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  n;
        int  snap_d0, snap_e0;
        logic exp_id;

        // Reset state.
        tick();
        chk("rst_busy",   {255'd0, o_busy}, 256'd0);
        chk("rst_result", o_result, 256'd0);
        chk("rst_core_a", o_core_a, 256'd0);
        chk("rst_pulses", {248'd0, o_ack0, o_ack1, o_done0, o_done1, o_err0, o_err1,
                           o_core_start, o_core_rst}, 256'd0);
        tick();
        i_rst = 1'b0;
        tick();

        // Single job: 4^13 mod 497 = 445.
        core_lat = 5;
        set_req0(256'd4, 256'd13, 256'd497);
        tick();
        chk("j1_ack0",   {255'd0, o_ack0}, 256'd1);
        chk("j1_start",  {255'd0, o_core_start}, 256'd1);
        chk("j1_core_a", o_core_a, 256'd4);
        chk("j1_busy",   {255'd0, o_busy}, 256'd1);
        i_req0 = 1'b0;
        tick();
        chk("j1_start_once", {255'd0, o_core_start}, 256'd0);
        wait_ev("j1_done", 1, 20, n);
        chk("j1_lat",    n, 256'd5);
        chk("j1_done0",  {254'd0, o_done0, o_done1}, 256'd2);
        chk("j1_result", o_result, 256'd445);
        tick();
        chk("j1_done_pulse", {255'd0, o_done0}, 256'd0);
        chk("j1_idle",       {255'd0, o_busy}, 256'd0);

        // Round robin from reset with both requests held: 0,1,0,1.
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        core_lat = 3;
        set_req0(256'd4, 256'd13, 256'd497);
        set_req1(256'd2, 256'd10, 256'd1000);   // 1024 mod 1000 = 24
        for (int g = 0; g < 4; g++) begin
            exp_id = g[0];
            wait_ev("rr_ack", 0, 10, n);
            chk($sformatf("rr%0d_ack", g), {254'd0, o_ack1, o_ack0},
                exp_id ? 256'd2 : 256'd1);
            wait_ev("rr_done", 1, 20, n);
            chk($sformatf("rr%0d_core_a", g), o_core_a, exp_id ? 256'd2 : 256'd4);
            chk($sformatf("rr%0d_result", g), o_result, exp_id ? 256'd24 : 256'd445);
        end
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        tick();
        tick();

        // Watchdog abort: the core never finishes.
        core_lat = 0;
        set_req0(256'd9, 256'd9, 256'd11);
        tick();
        chk("to_ack0", {255'd0, o_ack0}, 256'd1);
        i_req0 = 1'b0;
        wait_ev("to_end", 2, 40, n);
        chk("to_lat",    n, 256'd17);
        chk("to_err0",   {255'd0, o_err0}, 256'd1);
        chk("to_corerst",{255'd0, o_core_rst}, 256'd1);
        chk("to_nodone", {255'd0, o_done0}, 256'd0);
        chk("to_result", o_result, 256'd24);
        tick();
        chk("to_err_pulse", {254'd0, o_err0, o_core_rst}, 256'd0);
        // Next request accepted: 3^5 mod 7 = 5.
        core_lat = 3;
        set_req1(256'd3, 256'd5, 256'd7);
        wait_ev("to_next_ack", 0, 10, n);
        chk("to_next_ack1", {255'd0, o_ack1}, 256'd1);
        i_req1 = 1'b0;
        wait_ev("to_next_done", 1, 20, n);
        chk("to_next_result", o_result, 256'd5);

        // Finish in the same cycle as the watchdog limit: done wins.
        tick();
        core_lat = TO;
        set_req0(256'd4, 256'd13, 256'd497);
        tick();
        i_req0 = 1'b0;
        wait_ev("race_end", 2, 40, n);
        chk("race_lat",    n, 256'd17);
        chk("race_done0",  {255'd0, o_done0}, 256'd1);
        chk("race_noerr",  {254'd0, o_err0, o_core_rst}, 256'd0);
        chk("race_result", o_result, 256'd445);
        tick();

        // Reset during WAIT drops the job silently.
        core_lat = 0;
        set_req0(256'd7, 256'd3, 256'd100);
        tick();
        i_req0 = 1'b0;
        tick();
        tick();
        tick();
        snap_d0 = n_done0;
        snap_e0 = n_err0;
        i_rst = 1'b1;
        #1;
        chk("mr_busy",   {255'd0, o_busy}, 256'd0);
        chk("mr_result", o_result, 256'd0);
        chk("mr_core_a", o_core_a, 256'd0);
        tick();
        i_rst = 1'b0;
        core_lat = 3;
        set_req1(256'd3, 256'd5, 256'd7);
        wait_ev("mr_ack", 0, 10, n);
        chk("mr_ack1", {254'd0, o_ack1, o_ack0}, 256'd2);
        i_req1 = 1'b0;
        wait_ev("mr_done", 1, 20, n);
        chk("mr_done1",  {254'd0, o_done1, o_done0}, 256'd2);
        chk("mr_result2", o_result, 256'd5);
        tick();
        tick();
        chk("mr_no_stale_done", n_done0, snap_d0);
        chk("mr_no_stale_err",  n_err0,  snap_e0);

        // Spurious finish in IDLE and in START is ignored.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("sp_idle_result", o_result, 256'd5);
        chk("sp_idle_pulses", {252'd0, o_done0, o_done1, o_busy, o_err0}, 256'd0);
        set_req0(256'd4, 256'd13, 256'd497);
        tick();
        chk("sp_ack0", {255'd0, o_ack0}, 256'd1);
        i_req0 = 1'b0;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("sp_start_result", o_result, 256'd5);
        chk("sp_start_nodone", {254'd0, o_done0, o_done1}, 256'd0);
        chk("sp_start_busy",   {255'd0, o_busy}, 256'd1);
        wait_ev("sp_done", 1, 20, n);
        chk("sp_lat",    n, 256'd3);
        chk("sp_result", o_result, 256'd445);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
